// File: rtl/ring_output_arbiter_if.sv
// ============================================================================
// Module      : ring_output_arbiter_if
// Description : Requester/downstream bundle for one ring router output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ring_output_arbiter_if #(
    parameter int PACKET_SIZE = 64
);
    logic                   polarity;
    logic [1:0]             a_req;
    logic [1:0]             a_gnt;
    logic [PACKET_SIZE-1:0] a_data_even;
    logic [PACKET_SIZE-1:0] a_data_odd;
    logic [1:0]             b_req;
    logic [1:0]             b_gnt;
    logic [PACKET_SIZE-1:0] b_data_even;
    logic [PACKET_SIZE-1:0] b_data_odd;
    logic                   so;
    logic                   ro;
    logic [PACKET_SIZE-1:0] dout;

    // Arbiter side
    modport slave (
        output polarity,
        output a_gnt,
        output b_gnt,
        output so,
        output dout,
        input  a_req,
        input  a_data_even,
        input  a_data_odd,
        input  b_req,
        input  b_data_even,
        input  b_data_odd,
        input  ro
    );

    // Requester / downstream side
    modport master (
        input  polarity,
        input  a_gnt,
        input  b_gnt,
        input  so,
        input  dout,
        output a_req,
        output a_data_even,
        output a_data_odd,
        output b_req,
        output b_data_even,
        output b_data_odd,
        output ro
    );
endinterface

`default_nettype wire

// File: rtl/ring_output_arbiter.sv
// ============================================================================
// Module      : ring_output_arbiter
// Description : Two-VC output arbiter and staging buffer for the ring router;
//               alternates capture and send phases per VC using polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_output_arbiter #(
    parameter int PACKET_SIZE = 64,
    parameter int HOP_SHIFT   = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    ring_output_arbiter_if.slave   arb_if
);

    localparam int c_HOP_LSB = 48;
    localparam int c_HOP_MSB = 55;

    logic                   polarity_q, polarity_d;
    logic [1:0]             full_q, full_d;
    logic [1:0]             prio_q, prio_d;
    logic [PACKET_SIZE-1:0] buf_even_q, buf_even_d;
    logic [PACKET_SIZE-1:0] buf_odd_q, buf_odd_d;

    logic                   w_int_vc;
    logic                   w_ext_vc;
    logic                   w_a_req;
    logic                   w_b_req;
    logic                   w_cap;
    logic                   w_pick_b;
    logic                   w_so;
    logic [PACKET_SIZE-1:0] w_a_data;
    logic [PACKET_SIZE-1:0] w_b_data;
    logic [PACKET_SIZE-1:0] w_cap_data;
    logic [PACKET_SIZE-1:0] w_cap_pkt;
    logic [PACKET_SIZE-1:0] w_ext_buf;

    // The internal VC follows polarity; the other VC is in its send phase.
    assign w_int_vc = polarity_q;
    assign w_ext_vc = ~polarity_q;

    always_comb begin
        w_a_req    = arb_if.a_req[w_int_vc];
        w_b_req    = arb_if.b_req[w_int_vc];
        w_a_data   = w_int_vc ? arb_if.a_data_odd : arb_if.a_data_even;
        w_b_data   = w_int_vc ? arb_if.b_data_odd : arb_if.b_data_even;
        w_cap      = ~reset & ~full_q[w_int_vc] & (w_a_req | w_b_req);
        w_pick_b   = w_b_req & (~w_a_req | prio_q[w_int_vc]);
        w_cap_data = w_pick_b ? w_b_data : w_a_data;
        w_ext_buf  = w_ext_vc ? buf_odd_q : buf_even_q;
        w_so       = ~reset & full_q[w_ext_vc] & arb_if.ro;
    end

    generate
        if (HOP_SHIFT != 0) begin : g_hop_shift
            always_comb begin
                w_cap_pkt = w_cap_data;
                w_cap_pkt[c_HOP_MSB:c_HOP_LSB] = w_cap_data[c_HOP_MSB:c_HOP_LSB] >> 1;
            end
        end else begin : g_hop_pass
            assign w_cap_pkt = w_cap_data;
        end
    endgenerate

    assign arb_if.polarity = polarity_q;
    assign arb_if.a_gnt    = (w_cap & ~w_pick_b) ? (w_int_vc ? 2'b10 : 2'b01) : 2'b00;
    assign arb_if.b_gnt    = (w_cap &  w_pick_b) ? (w_int_vc ? 2'b10 : 2'b01) : 2'b00;
    assign arb_if.so       = w_so;
    assign arb_if.dout     = reset ? '0 : w_ext_buf;

    always_comb begin
        polarity_d = ~polarity_q;
        full_d     = full_q;
        prio_d     = prio_q;
        buf_even_d = buf_even_q;
        buf_odd_d  = buf_odd_q;
        if (w_cap) begin
            if (w_int_vc) begin
                buf_odd_d = w_cap_pkt;
            end else begin
                buf_even_d = w_cap_pkt;
            end
            full_d[w_int_vc] = 1'b1;
            // Round-robin: the next contended grant favours the loser.
            prio_d[w_int_vc] = ~w_pick_b;
        end
        if (w_so) begin
            full_d[w_ext_vc] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity_q <= 1'b0;
            full_q     <= 2'b00;
            prio_q     <= 2'b00;
            buf_even_q <= '0;
            buf_odd_q  <= '0;
        end else begin
            polarity_q <= polarity_d;
            full_q     <= full_d;
            prio_q     <= prio_d;
            buf_even_q <= buf_even_d;
            buf_odd_q  <= buf_odd_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/ring_output_arbiter.md
# ring_output_arbiter

Output-port arbiter and staging buffer for the bidirectional ring router. It shares one router output channel (cw, ccw or pe) between two requesting input buffers. Each output has two virtual channels (even/odd), and the arbiter alternates internal (arbitrate/capture) and external (send) phases per VC using the router polarity. The router instantiates one of these per output port: cw output (requesters: cw input, pe input), ccw output (ccw input, pe input), pe output (cw input, ccw input).

## Interface
- PACKET_SIZE, 64, packet width in bits; bit 62 = direction, bits [55:48] = hop field
- HOP_SHIFT, 1, 1: hop field right-shifted by one on capture; 0: packet passes unmodified

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- polarity  out  1  router phase; 0 = even VC internal / odd VC external; 1 = the reverse
- a_req  in  2  requester A has a packet for VC v (bit v: 0 = even, 1 = odd)
- a_data_even, a_data_odd  in  PACKET_SIZE  requester A head packet per VC
- a_gnt  out  2  one-hot grant to A for VC v; requester pops on gnt
- b_req, b_data_even, b_data_odd, b_gnt  same as A, for requester B
- so  out  1  send valid to downstream
- ro  in  1  downstream ready
- dout  out  PACKET_SIZE  packet to downstream

## Operation
- polarity register: 0 after reset, toggles every cycle thereafter.
- State per VC v:
  - full[v]: output buffer occupied.
  - buf[v]: PACKET_SIZE packet.
  - prio[v]: 0 = A preferred, 1 = B preferred.
- Internal phase, VC p = polarity:
  - If !full[p] and (a_req[p] | b_req[p]), grant exactly one requester, combinationally in the same cycle.
  - Single requester: that requester is granted.
  - Both requesting: the requester selected by prio[p] is granted.
  - On any grant, prio[p] is set to point at the other requester (round-robin).
  - At the edge: buf[p] <= granted data, with hop[55:48] >> 1 if HOP_SHIFT = 1; full[p] <= 1.
  - If full[p] = 1: no grant, prio[p] unchanged.
  - a_gnt[~p] = b_gnt[~p] = 0 always.
- External phase, VC q = ~polarity:
  - so = full[q] & ro; dout = buf[q].
  - When so = 1, full[q] is cleared at the edge. The buffer contents may remain but are ignored.
  - ro = 0: packet held; so = 0.
- A VC is never captured and drained in the same cycle; the phases are exclusive per cycle.
- Requests on one VC never affect the other VC's buffer or priority.

## Timing
- Reset (synchronous): polarity = 0, full = 2'b00, prio = 2'b00, buf = 0, so = 0, dout = 0, a_gnt = b_gnt = 0. Grants are forced to 0 while reset is high.
- Latency: packet granted in cycle n (polarity = p) is offered at cycle n+1 (polarity = ~p). Earliest so = 1 is cycle n+1 if ro = 1.
- Stall: an undrained packet is re-offered every second cycle (its external phase) until ro = 1.
- Throughput: one packet per VC per 2 cycles, two VCs interleaved, giving one packet per cycle per output.
- Reset mid-operation: buffered packets are discarded (no so), priority returns to A, and polarity restarts at 0 in the first cycle after reset deasserts.
- Hop field: 8-bit logical right shift; 8'h01 becomes 8'h00 and 8'h00 stays 8'h00. Only bits [55:48] are modified.

## Test plan
- Reset hold 5 cycles, then release → during reset so = 0, dout = 0, gnts = 0, polarity = 0. After release polarity goes 0,1,0,1.
- A only, a_req = 01, hop 8'h04, at polarity 0, ro = 1 → a_gnt = 01 that cycle. Next cycle so = 1, dout[55:48] = 8'h02, other bits unchanged. Following even cycle: buffer empty.
- Contention on even VC, both a_req[0] and b_req[0] held after reset → first even cycle a_gnt = 01; next even cycle b_gnt = 01; then A again (alternation).
- Backpressure: ro = 0 with even buffer full → so = 0 and no even grants for 6 cycles. Raise ro in an odd-polarity cycle → so = 1, then grant in the next even cycle.
- VC independence: even buffer stalled (ro = 0 on even drain only), b_req = 10 → b_gnt = 10 at polarity 1, odd packet drained at polarity 0 when ro = 1; even priority unchanged.
- Reset asserted with both buffers full and prio = 2'b11 → after release no so until new grants; first contended grant on each VC goes to A.
